// File: rtl/bus_sync_blink.sv
// bus_sync_blink: CLK1-domain strobe/PHI synchronisers, PHI edge pulse and blink dividers (blinks built only with BUS_SYNC_BLINK_EN)
module bus_sync_blink #(
  parameter int SYNC_STAGES  = 2,
  parameter int PHI_DIV_BITS = 23,
  parameter int CLK_DIV_BITS = 24
) (
  input  logic CLK1,
  input  logic RST,
  input  logic PHI,
  input  logic IORQ,
  input  logic RD,
  input  logic WR,
  output logic io_read,
  output logic io_write,
  output logic phi_read,
  output logic phi_edge,
  output logic blink1,
  output logic blink2
);
  if (SYNC_STAGES < 2 || PHI_DIV_BITS < 1 || CLK_DIV_BITS < 1) begin : g_bad_cfg
    $error("bus_sync_blink: illegal parameter set");
  end
  logic rd_req, wr_req, phi_prev;
  logic [SYNC_STAGES-1:0] rd_sync, wr_sync, phi_sync;
  assign rd_req = ~IORQ & ~RD;
  assign wr_req = ~IORQ & ~WR;
  // decoded strobes and PHI each ripple through their own chain; phi_prev trails phi_read by one cycle
  always_ff @(posedge CLK1) begin
    rd_sync  <= RST ? '0 : {rd_sync[SYNC_STAGES-2:0], rd_req};
    wr_sync  <= RST ? '0 : {wr_sync[SYNC_STAGES-2:0], wr_req};
    phi_sync <= RST ? '0 : {phi_sync[SYNC_STAGES-2:0], PHI};
    phi_prev <= RST ? 1'b0 : phi_read;
  end
  assign io_read  = rd_sync[SYNC_STAGES-1];
  assign io_write = wr_sync[SYNC_STAGES-1];
  assign phi_read = phi_sync[SYNC_STAGES-1];
  assign phi_edge = phi_read & ~phi_prev;
`ifdef BUS_SYNC_BLINK_EN
  logic [PHI_DIV_BITS-1:0] phi_cnt;
  logic [CLK_DIV_BITS-1:0] clk_cnt;
  // phi_cnt counts PHI rising edges, clk_cnt counts CLK1 cycles; reset beats increment
  always_ff @(posedge CLK1) begin
    phi_cnt <= RST ? '0 : phi_cnt + PHI_DIV_BITS'(phi_edge);
    clk_cnt <= RST ? '0 : clk_cnt + CLK_DIV_BITS'(1);
  end
  assign blink1 = phi_cnt[PHI_DIV_BITS-1];
  assign blink2 = clk_cnt[CLK_DIV_BITS-1];
`else
  assign blink1 = 1'b0;
  assign blink2 = 1'b0;
`endif
endmodule

// File: tb/tb_bus_sync_blink.sv
// tb_bus_sync_blink: vector table, directed corner sequences and random stimulus against an edge-history model
module tb_bus_sync_blink;
  localparam int S = 2, PB = 3, CB = 4, MAXE = 4096;
`ifdef BUS_SYNC_BLINK_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif
  logic CLK1 = 1'b0, RST = 1'b1, PHI = 1'b0, IORQ = 1'b1, RD = 1'b1, WR = 1'b1;
  logic io_read, io_write, phi_read, phi_edge, blink1, blink2;
  logic [5:0] got;
  int tests = 0, fails = 0, k = 0;
  bit s_rd[MAXE], s_wr[MAXE], s_phi[MAXE];
  int lr[MAXE], ecum[MAXE];
  typedef struct {logic iorq, rd, wr, phi; logic [2:0] exp;} vec_t;
  vec_t vt[8];
  always #5 CLK1 = ~CLK1;
  bus_sync_blink #(.SYNC_STAGES(S), .PHI_DIV_BITS(PB), .CLK_DIV_BITS(CB)) dut (
    .CLK1(CLK1), .RST(RST), .PHI(PHI), .IORQ(IORQ), .RD(RD), .WR(WR),
    .io_read(io_read), .io_write(io_write), .phi_read(phi_read),
    .phi_edge(phi_edge), .blink1(blink1), .blink2(blink2));
  assign got = {io_read, io_write, phi_read, phi_edge, blink1, blink2};
  // synchronised value after edge j: the input sampled S-1 edges earlier, zero if a reset edge lies between
  function automatic bit sync_at(int j, int sel);
    int src;
    src = j - S + 1;
    if (j < 1 || src <= lr[j]) return 1'b0;
    return sel == 0 ? s_rd[src] : sel == 1 ? s_wr[src] : s_phi[src];
  endfunction
  function automatic bit edge_at(int j);
    return j >= 1 && sync_at(j, 2) && !sync_at(j - 1, 2);
  endfunction
  function automatic logic [5:0] exp_out(int j);
    int pc, cc;
    pc = j > lr[j] ? ecum[j-1] - ecum[lr[j]] : 0;
    cc = j - lr[j];
    return {sync_at(j, 0), sync_at(j, 1), sync_at(j, 2), edge_at(j),
            BEN && (pc % (2**PB)) >= 2**(PB-1), BEN && (cc % (2**CB)) >= 2**(CB-1)};
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s @edge %0d: got %0h want %0h", name, k, act, want);
    end
  endtask
  task automatic tick();
    k++;
    if (k >= MAXE) begin
      $display("FAIL edge_budget: got %0d edges want < %0d", k, MAXE);
      $fatal(1);
    end
    s_rd[k] = !IORQ && !RD;
    s_wr[k] = !IORQ && !WR;
    s_phi[k] = PHI;
    lr[k] = RST ? k : lr[k-1];
    @(posedge CLK1);
    #1;
    ecum[k] = ecum[k-1] + int'(edge_at(k));
    check("model", got, exp_out(k));
  endtask
  initial begin
    int pulses, misplaced, base;
    logic [8:0] pat, wpat;
    logic [5:0] epat;
    vt[0] = '{1, 1, 1, 0, 3'b000};
    vt[1] = '{0, 0, 1, 0, 3'b100};
    vt[2] = '{0, 1, 0, 0, 3'b010};
    vt[3] = '{0, 0, 0, 1, 3'b111};
    vt[4] = '{1, 0, 0, 1, 3'b001};
    vt[5] = '{0, 1, 1, 1, 3'b001};
    vt[6] = '{1, 0, 1, 0, 3'b000};
    vt[7] = '{0, 0, 0, 0, 3'b110};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_idle", got, 6'b0);
    end
    RST = 1'b0;
    tick();
    PHI = 1'b1;
    tick();
    check("resume_phi_lag", phi_read, 1'b0);
    tick();
    check("resume_phi_read", phi_read, 1'b1);
    check("resume_phi_edge", phi_edge, 1'b1);
    tick();
    check("resume_edge_once", phi_edge, 1'b0);
    PHI = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int v = 0; v < 8; v++) begin
      {IORQ, RD, WR, PHI} = {vt[v].iorq, vt[v].rd, vt[v].wr, vt[v].phi};
      for (int i = 0; i < 3; i++) tick();
      check($sformatf("vec%0d", v), {io_read, io_write, phi_read}, vt[v].exp);
    end
    {IORQ, RD, WR, PHI} = 4'b1110;
    for (int i = 0; i < 3; i++) tick();
    IORQ = 1'b0;
    RD = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 6) {IORQ, RD} = 2'b11;
      tick();
      pat[9-i] = io_read;
      wpat[9-i] = io_write;
    end
    check("io_read_window", pat, 9'b011111000);
    check("io_write_quiet", wpat, 9'b0);
    WR = 1'b0;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[i] = io_read | io_write;
    end
    check("wr_without_iorq", pat[3:0], 4'b0);
    WR = 1'b1;
    pulses = 0;
    misplaced = 0;
    base = k;
    for (int p = 0; p < 10; p++)
      for (int i = 0; i < 6; i++) begin
        PHI = i < 3;
        tick();
        if (phi_edge) begin
          pulses++;
          if ((k - base - 1) % 6 != 1) misplaced++;
        end
      end
    PHI = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (phi_edge) pulses++;
    end
    check("phi_pulse_count", pulses, 10);
    check("phi_pulse_place", misplaced, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    check("blink2_low", blink2, 1'b0);
    tick();
    check("blink2_high", blink2, BEN);
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        PHI = i < 2;
        tick();
      end
      if (p == 2) check("blink1_low", blink1, 1'b0);
    end
    check("blink1_high", blink1, BEN);
    RST = 1'b1;
    tick();
    check("mid_reset", got, 6'b0);
    RST = 1'b0;
    tick();
    check("after_mid_reset", {blink1, blink2}, 2'b0);
    PHI = 1'b1;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("phi_high_reset", got, 6'b0);
    end
    RST = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      epat[6-i] = phi_edge;
    end
    check("phi_high_release", epat, 6'b010000);
    for (int i = 0; i < 1500; i++) begin
      RST = ($urandom % 64) == 0;
      IORQ = ($urandom % 3) != 0;
      RD = $urandom % 2;
      WR = $urandom % 2;
      if (($urandom % 3) == 0) PHI = ~PHI;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
